// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential advance, jump, PC-relative branch and
// call/return through an internal return-address stack. Define STACK_TRAP_EN to vector stack errors to TRAP_VECTOR.
module pc_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned SIZE_WIDTH  = 2,
    parameter int unsigned TRAP_VECTOR = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic [2:0]                         op,
    input  logic [SIZE_WIDTH-1:0]              instr_size,
    input  logic [ADDR_WIDTH-1:0]              target,
    input  logic                               err_clr,
    output logic [ADDR_WIDTH-1:0]              pc,
    output logic [ADDR_WIDTH-1:0]              pc_next,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int unsigned SPW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] TRAP_PC = ADDR_WIDTH'(TRAP_VECTOR);
`ifdef STACK_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]        sp_q, sp_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];

    logic [SIZE_WIDTH-1:0] size_eff;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] err_pc;
    logic [ADDR_WIDTH-1:0] top_entry;
    logic                  full, empty;

    always_comb begin
        size_eff  = (instr_size == '0) ? SIZE_WIDTH'(1) : instr_size;
        seq_pc    = pc_q + ADDR_WIDTH'(size_eff);
        err_pc    = TRAP_EN ? TRAP_PC : seq_pc;
        full      = (sp_q == SPW'(STACK_DEPTH));
        empty     = (sp_q == '0);
        top_entry = stack_q[IDXW'(sp_q - SPW'(1))];
    end

    // Next-state: stall freezes pc/stack, but err_clr still applies; a new error overrides the clear.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        ovf_d   = err_clr ? 1'b0 : ovf_q;
        unf_d   = err_clr ? 1'b0 : unf_q;
        if (!stall) begin
            case (op)
                OP_JUMP:   pc_d = target;
                // Equal-width add is the sign-extended offset add modulo 2^ADDR_WIDTH.
                OP_BRANCH: pc_d = pc_q + target;
                OP_CALL: begin
                    if (full) begin
                        ovf_d = 1'b1;
                        pc_d  = err_pc;
                    end else begin
                        stack_d[IDXW'(sp_q)] = seq_pc;
                        sp_d                 = sp_q + SPW'(1);
                        pc_d                 = target;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        unf_d = 1'b1;
                        pc_d  = err_pc;
                    end else begin
                        pc_d = top_entry;
                        sp_d = sp_q - SPW'(1);
                    end
                end
                default:   pc_d = seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            stack_q <= '{default: '0};
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            stack_q <= stack_d;
        end
    end

    assign pc          = pc_q;
    assign pc_next     = pc_d;
    assign sp          = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (default parameters); honours STACK_TRAP_EN.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic [2:0] op;
    logic [1:0] instr_size;
    logic [7:0] target;
    logic       err_clr;
    logic [7:0] pc, pc_next;
    logic [2:0] sp;
    logic       stack_full, stack_empty, overflow, underflow;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .op(op), .instr_size(instr_size),
        .target(target), .err_clr(err_clr), .pc(pc), .pc_next(pc_next), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

`ifdef STACK_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [7:0] TV = 8'h00;

    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BRA = 3'd2, CAL = 3'd3, RET = 3'd4;

    typedef struct {
        logic       stall;
        logic [2:0] op;
        logic [1:0] size;
        logic [7:0] tgt;
        logic       clr;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic [2:0] o, logic [1:0] s, logic [7:0] t,
                                logic c, logic [7:0] p, logic [2:0] spv, logic ov, logic un);
        vec_t v;
        v.stall = st; v.op = o; v.size = s; v.tgt = t; v.clr = c;
        v.pc = p; v.sp = spv; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] o, input logic [1:0] s,
                         input logic [7:0] t, input logic c);
        stall = st; op = o; instr_size = s; target = t; err_clr = c;
    endtask

    logic [7:0] p_ovf, p_un1, p_un2, p_un3;

    initial begin
        drive(1'b0, SEQ, 2'd1, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_pc", pc, 0);
        chk("reset_sp", sp, 0);
        chk("reset_empty", stack_empty, 1);
        chk("reset_full", stack_full, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_unf", underflow, 0);

        p_ovf = TRAP ? TV : 8'h61;
        p_un1 = TRAP ? TV : 8'h41;
        p_un2 = TRAP ? TV : 8'h42;
        p_un3 = p_un2 + 8'd1;

        vecs.push_back(mk(0, SEQ, 2'd1, 8'h00, 0, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, SEQ, 2'd2, 8'h00, 0, 8'h03, 0, 0, 0));
        vecs.push_back(mk(0, SEQ, 2'd3, 8'h00, 0, 8'h06, 0, 0, 0));
        vecs.push_back(mk(0, SEQ, 2'd0, 8'h00, 0, 8'h07, 0, 0, 0));
        vecs.push_back(mk(0, JMP, 2'd1, 8'hFE, 0, 8'hFE, 0, 0, 0));
        vecs.push_back(mk(0, SEQ, 2'd3, 8'h00, 0, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, JMP, 2'd1, 8'h10, 0, 8'h10, 0, 0, 0));
        vecs.push_back(mk(0, BRA, 2'd1, 8'hF8, 0, 8'h08, 0, 0, 0));
        vecs.push_back(mk(0, JMP, 2'd1, 8'hFC, 0, 8'hFC, 0, 0, 0));
        vecs.push_back(mk(0, BRA, 2'd1, 8'h08, 0, 8'h04, 0, 0, 0));
        vecs.push_back(mk(0, 3'd7, 2'd2, 8'h55, 0, 8'h06, 0, 0, 0));
        vecs.push_back(mk(0, JMP, 2'd1, 8'h20, 0, 8'h20, 0, 0, 0));
        vecs.push_back(mk(0, CAL, 2'd3, 8'h80, 0, 8'h80, 1, 0, 0));
        vecs.push_back(mk(0, RET, 2'd1, 8'h00, 0, 8'h23, 0, 0, 0));
        vecs.push_back(mk(0, JMP, 2'd1, 8'h20, 0, 8'h20, 0, 0, 0));
        vecs.push_back(mk(0, CAL, 2'd3, 8'h80, 0, 8'h80, 1, 0, 0));
        vecs.push_back(mk(0, JMP, 2'd1, 8'h84, 0, 8'h84, 1, 0, 0));
        vecs.push_back(mk(0, CAL, 2'd2, 8'h90, 0, 8'h90, 2, 0, 0));
        vecs.push_back(mk(0, RET, 2'd1, 8'h00, 0, 8'h86, 1, 0, 0));
        vecs.push_back(mk(0, RET, 2'd1, 8'h00, 0, 8'h23, 0, 0, 0));
        // fill the stack, then overflow on the fifth call
        vecs.push_back(mk(0, CAL, 2'd1, 8'h30, 0, 8'h30, 1, 0, 0));
        vecs.push_back(mk(0, CAL, 2'd1, 8'h40, 0, 8'h40, 2, 0, 0));
        vecs.push_back(mk(0, CAL, 2'd1, 8'h50, 0, 8'h50, 3, 0, 0));
        vecs.push_back(mk(0, CAL, 2'd1, 8'h60, 0, 8'h60, 4, 0, 0));
        vecs.push_back(mk(0, CAL, 2'd1, 8'h70, 0, p_ovf, 4, 1, 0));
        vecs.push_back(mk(1, CAL, 2'd1, 8'h99, 1, p_ovf, 4, 0, 0));
        vecs.push_back(mk(0, RET, 2'd1, 8'h00, 0, 8'h51, 3, 0, 0));
        vecs.push_back(mk(0, RET, 2'd1, 8'h00, 0, 8'h41, 2, 0, 0));
        vecs.push_back(mk(0, RET, 2'd1, 8'h00, 0, 8'h31, 1, 0, 0));
        vecs.push_back(mk(0, RET, 2'd1, 8'h00, 0, 8'h24, 0, 0, 0));
        // underflow; clear together with a new error keeps the flag set
        vecs.push_back(mk(0, JMP, 2'd1, 8'h40, 0, 8'h40, 0, 0, 0));
        vecs.push_back(mk(0, RET, 2'd1, 8'h00, 0, p_un1, 0, 0, 1));
        vecs.push_back(mk(0, RET, 2'd1, 8'h00, 1, p_un2, 0, 0, 1));
        vecs.push_back(mk(0, SEQ, 2'd1, 8'h00, 1, p_un3, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].op, vecs[i].size, vecs[i].tgt, vecs[i].clr);
            #1;
            chk($sformatf("v%0d_pc_next", i), pc_next, vecs[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            chk($sformatf("v%0d_sp", i), sp, vecs[i].sp);
            chk($sformatf("v%0d_full", i), stack_full, (vecs[i].sp == 3'd4) ? 1 : 0);
            chk($sformatf("v%0d_empty", i), stack_empty, (vecs[i].sp == 3'd0) ? 1 : 0);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ov);
            chk($sformatf("v%0d_unf", i), underflow, vecs[i].un);
            @(negedge clk);
        end

        // asynchronous reset between edges after two calls
        drive(0, CAL, 2'd1, 8'hA0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, CAL, 2'd1, 8'hB0, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_pc", pc, 8'hB0);
        chk("pre_rst_sp", sp, 2);
        drive(0, RET, 2'd1, 8'h00, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 0);
        chk("async_rst_sp", sp, 0);
        chk("async_rst_empty", stack_empty, 1);
        @(negedge clk);
        rst = 1'b0;
        // stack contents gone: a RET now underflows
        @(posedge clk);
        #1;
        chk("post_rst_unf", underflow, 1);
        chk("post_rst_pc", pc, TRAP ? TV : 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
